// File: rtl/fp_pkg.sv
// Shared FP32 field constants and result-class encoding
// for the single-precision adder datapath.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  localparam int CLS_ZERO = 0;
  localparam int CLS_SUB  = 1;
  localparam int CLS_INF  = 2;
  localparam int CLS_NAN  = 3;

  typedef logic [3:0] fp_class_t;

  typedef struct packed {
    logic [31:0] data;
    fp_class_t   cls;
    logic        sign;
  } fp_entry_t;

endpackage

// File: rtl/fp_add_result_buf_if.sv
// Adder-result beat input and consumer valid/ready
// output of the result buffer.
interface fp_add_result_buf_if;
  import fp_pkg::*;

  logic        in_valid;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  fp_class_t   out_class;
  logic        out_sign;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_class,
    output out_sign
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_class,
    input  out_sign
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 FP32 classifier: one-hot class
// (zero/sub/inf/nan, all clear = normal) plus sign.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] val_i,
  output fp_class_t   cls_o,
  output logic        sign_o
);

  logic [FP_EXP_W-1:0]  exp_w;
  logic [FP_FRAC_W-1:0] frac_w;
  logic                 frac_nz;

  assign exp_w   = val_i[FP_EXP_W+FP_FRAC_W-1:FP_FRAC_W];
  assign frac_w  = val_i[FP_FRAC_W-1:0];
  assign frac_nz = |frac_w;
  assign sign_o  = val_i[31];

  always_comb begin
    cls_o = '0;
    unique case (1'b1)
      (exp_w == '0): begin
        if (frac_nz) cls_o[CLS_SUB]  = 1'b1;
        else         cls_o[CLS_ZERO] = 1'b1;
      end
      (exp_w == FP_EXP_MAX): begin
        if (frac_nz) cls_o[CLS_NAN] = 1'b1;
        else         cls_o[CLS_INF] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fp_add_result_buf.sv
// FWFT result FIFO behind the FP adder: classifies on write,
// counts beats lost while full (saturating, sticky flag).
module fp_add_result_buf
  import fp_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int DROP_W = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_add_result_buf_if.slave bus,
  input  logic               clr_ovf,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);

  fp_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;

  fp_class_t wr_cls;
  logic      wr_sign;
  fp_entry_t wr_entry;
  fp_entry_t head;

  logic full_w, empty_w;
  logic push, pop, drop;

  fp_classify u_cls (
    .val_i  (bus.in_data),
    .cls_o  (wr_cls),
    .sign_o (wr_sign)
  );

  assign wr_entry = '{
    data: bus.in_data,
    cls:  wr_cls,
    sign: wr_sign
  };

  assign full_w  = (cnt_q == CNT_W'(DEPTH));
  assign empty_w = (cnt_q == '0);

  // A full FIFO still takes a beat when the head leaves the same cycle.
  assign pop  = !empty_w & bus.out_ready;
  assign push = bus.in_valid & (!full_w | pop);
  assign drop = bus.in_valid & full_w & !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Clear and drop in the same cycle leaves that one drop recorded.
  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (clr_ovf) begin
      drop_d = drop ? DROP_W'(1) : '0;
      ovf_d  = drop;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = mem_q[rd_ptr_q];

  assign bus.out_valid = !empty_w;
  assign bus.out_data  = head.data;
  assign bus.out_class = head.cls;
  assign bus.out_sign  = head.sign;

  assign count    = cnt_q;
  assign full     = full_w;
  assign empty    = empty_w;
  assign drop_cnt = drop_q;
  assign overflow = ovf_q;

endmodule

// File: doc/fp_add_result_buf.md
Name: fp_add_result_buf

Overview:
Downstream result buffer for the single-precision adder. The adder has no backpressure, so this block must capture every out_valid/result beat into a FIFO. Each stored result is tagged with an IEEE-754 class. The block then presents entries to the consumer with a valid/ready handshake. Drops on overflow are counted and flagged sticky so software and the bench can detect lost results.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 2
DROP_W, 8, width of saturating drop counter
CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  result beat present (driven by adder out_valid)
in_data  input  32  FP32 result (driven by adder result)
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head this cycle
out_data  output  32  head FP32 value
out_class  output  4  head class: bit0 zero, bit1 subnormal, bit2 inf, bit3 NaN; all 0 = normal
out_sign  output  1  head sign bit (in_data[31] at capture)
count  output  CNT_W  entries held
full  output  1  count == DEPTH
empty  output  1  count == 0
drop_cnt  output  DROP_W  beats lost while full; saturates at all-ones
overflow  output  1  sticky: at least one drop since last clear
clr_ovf  input  1  clears drop_cnt and overflow

Behaviour:
- Reset (rst_n low at an edge), applies mid-operation too:
  - Pointers cleared; contents discarded.
  - Outputs: out_valid=0, count=0, empty=1, full=0, drop_cnt=0, overflow=0.
  - out_data, out_class and out_sign are don't-care while out_valid=0.
- pop = out_valid & out_ready.
- push = in_valid & (!full | pop). A full FIFO accepts a beat in the same cycle it pops.
- drop = in_valid & full & !pop. On a drop, stored data is untouched.
- count next = count + push - pop. full and empty are derived from count, never from pointers alone.
- Pointers are log2(DEPTH) bits and wrap naturally; no special case at DEPTH-1 → 0.
- Storage is first-word-fall-through.
  - If in_valid is sampled at edge N into an empty FIFO, out_valid=1 and out_data is valid after edge N, in the same cycle the adder's result stops.
  - There is no bypass from in_data to out_data combinationally.
- Classification is computed at write from in_data, using exp = bits[30:23] and frac = bits[22:0], and stored alongside the data:
  - zero: exp==0 and frac==0
  - subnormal: exp==0 and frac!=0
  - inf: exp==255 and frac==0
  - NaN: exp==255 and frac!=0
- A pop with out_valid=0 is a no-op. out_ready is ignored when the FIFO is empty.
- drop_cnt increments by 1 per drop and holds at 2^DROP_W-1. overflow is set on any drop.
- clr_ovf resets drop_cnt and overflow. If clr_ovf and a drop occur in the same cycle, the result is drop_cnt=1 and overflow=1.
- All outputs are registered or derived from registered state only.

Decomposition:
- Package fp_pkg holds:
  - FP32 constants FP_EXP_W=8, FP_FRAC_W=23, FP_EXP_MAX=8'hFF.
  - Class bit index constants CLS_ZERO=0, CLS_SUB=1, CLS_INF=2, CLS_NAN=3.
  - typedef fp_class_t (4-bit).
- One sub-module, fp_classify: combinational, 32-bit input, outputs fp_class_t and sign. It is reused by later FP stages.
- FIFO control and storage stay in fp_add_result_buf.

Test Plan:
- Single beat, empty FIFO, out_ready=0: in_data=0x3F400000 at edge N → after N: out_valid=1, out_data=0x3F400000, out_class=0000, out_sign=0, count=1. Then out_ready=1 for one cycle → empty=1, out_valid=0.
- Fill with out_ready=0, 8 beats 0x3F800000..0x3F800007 → full=1, count=8. 9th beat 0x40700000 → dropped, drop_cnt=1, overflow=1. Drain → order 0x3F800000..0x3F800007, no 0x40700000.
- While full, in_valid=1 (0x40C5C28F) and out_ready=1 in the same cycle → head popped, new beat stored, count stays 8, drop_cnt unchanged, 0x40C5C28F emerges last.
- Classification: 0x00000000→0001, 0x00000001→0010, 0x7F800000→0100, 0x7FC00000→1000, 0xFF800000→0100 with out_sign=1, 0x3F000000→0000.
- Saturation and clear:
  - 260 drops → drop_cnt=0xFF.
  - clr_ovf alone → drop_cnt=0, overflow=0.
  - clr_ovf coincident with a drop → drop_cnt=1, overflow=1.
- Reset mid-operation: 3 beats stored, drop_cnt=2, rst_n low for one edge → count=0, empty=1, out_valid=0, drop_cnt=0, overflow=0. The next pushed beat is the first one read out.
